rtc_bus_responder: RTL and testbench
====================================

// Module: rtc_bus_responder
// PURPOSE
//  Synthesizable responder for the V3023-style multiplexed RTC bus, the far end of our bus master.
//  Decodes the active-low ~A/D, CS, RD and WR strobes and an 8-bit AD bus: address phase, then read or write data phase.
//  Backs the bus with a 16-byte register file; registers 0x00-0x02 run as a BCD seconds/minutes/hours clock.
//  Used as an on-FPGA RTC stand-in for loopback bring-up and as the DUT partner in master benches.
// PARAMETERS
//  TICK_DIV  100_000_000  clk cycles per 1 s tick (>=2)
//  TIMEOUT   63           max cycles in WAIT_DATA before abort (>=1)
// PORTS
//  clk        in   1   system clock, 100 MHz
//  reset      in   1   asynchronous, active-high reset
//  AD         in   1   ~A/D, low = address phase (active-low)
//  CS         in   1   chip select, active-low
//  RD         in   1   read strobe, active-low
//  WR         in   1   write strobe, active-low
//  ad_in      in   8   AD bus value driven by master
//  ad_out     out  8   read data to AD bus
//  ad_oe      out  1   1 = responder drives AD bus
//  wr_strobe  out  1   1-cycle pulse: register written from bus
//  rd_strobe  out  1   1-cycle pulse: read data phase started
//  bus_err    out  1   1-cycle pulse: aborted or timed-out access
//  time_out   out  24  {hours,minutes,seconds} BCD
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, regs 0x00-0x0E = 0x00, reg 0x0F = 0x01 (RUN=1), prescaler 0.
//  AD/CS/RD/WR/ad_in pass a 2-flop synchronizer (inputs async); sync'd strobes reset to 1, ad_in to 0.
//  Edges are taken on the sync'd copies; response latency to any bus edge is 2-3 clk.
//  FSM:
//   IDLE      : AD=0 & CS=0 & WR=0 -> ADDR.
//   ADDR      : WR 0->1 with AD=0 -> latch addr=ad_in (value at the last WR-low cycle) -> WAIT_DATA.
//               CS 0->1 before WR rises -> IDLE + bus_err.
//   WAIT_DATA : AD=1 & CS=0 & RD=0 -> READ, rd_strobe; AD=1 & CS=0 & WR=0 -> WRITE.
//               RD and WR both low -> IDLE + bus_err. After TIMEOUT cycles here -> IDLE + bus_err.
//   READ      : ad_out latched once on entry (stable while driven), ad_oe=1.
//               RD or CS rising -> ad_oe=0 next cycle -> IDLE.
//   WRITE     : WR 0->1 -> reg[addr]=ad_in (last WR-low value), wr_strobe -> IDLE.
//               CS rising first -> IDLE + bus_err, no write.
//  AD returning low in WAIT_DATA/READ/WRITE: abort to IDLE, bus_err, ad_oe=0. Re-arm from IDLE next cycle.
//  Address: addr[7:4]!=0 -> writes ignored (no wr_strobe), reads return 0x00.
//  Timekeeping: prescaler counts 0..TICK_DIV-1 and wraps; tick fires on wrap only while reg0x0F[0]=1.
//   Tick: sec+1 in BCD. Low nibble >=9 -> low 0, high+1. Sec >=0x59 (binary compare) -> 0x00 + carry to min.
//   Min: same rule. Hour: >=0x23 -> 0x00.
//   Out-of-range BCD written by bus is stored as-is; the next tick normalises it via the rules above.
//  Bus write and tick in the same cycle: bus write wins on its register; the tick is dropped for that cycle.
//  Regs 0x03-0x0E are plain scratch RAM; reg0x0F bits[7:1] are stored but unused.
//  Async reset mid-access: immediate return to IDLE, ad_oe=0, no partial write.
// TESTING
//  1 Write: addr phase 0x05 then data 0xA5 (6-cycle CS windows) -> one wr_strobe, reg5=0xA5, bus_err=0.
//  2 Read: addr 0x05 then RD low 8 cycles -> rd_strobe; ad_oe=1 with ad_out=0xA5 until RD rises; ad_oe=0 within 3 clk.
//  3 Rollover (TICK_DIV=4): write 0x59,0x59,0x23 to regs 0-2 -> after next tick time_out=24'h000000.
//  4 Out-of-range: addr 0x20 write 0x11 -> no wr_strobe; read 0x20 -> 0x00. Write sec=0x7A -> next tick sec=0x00, min+1.
//  5 Abort: CS rises during ADDR -> bus_err pulse, IDLE. WAIT_DATA held 64 cycles -> bus_err, IDLE, regs unchanged.
//  6 Reset asserted during READ -> ad_oe=0 immediately; all regs 0 except reg0x0F=0x01.

Source files
------------

// File: rtl/rtc_bus_responder.sv
// Responder for a V3023-style multiplexed RTC bus, backed by a 16-byte register file.
// Registers 0x00-0x02 run as a BCD seconds/minutes/hours clock. Register 0x0F bit 0 is RUN.
module rtc_bus_responder #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned TIMEOUT  = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        AD,
  input  logic        CS,
  input  logic        RD,
  input  logic        WR,
  input  logic [7:0]  ad_in,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  output logic        wr_strobe,
  output logic        rd_strobe,
  output logic        bus_err,
  output logic [23:0] time_out
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StAddr, StWait, StRead, StWrite} state_t;

  // Strobe vectors are ordered {AD, CS, RD, WR}
  logic [3:0]    meta_q, sync_q, prev_q;
  logic [7:0]    data_meta_q, data_sync_q, data_prev_q;
  state_t        state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [7:0]    ad_out_q, ad_out_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic          rd_strobe_q, rd_strobe_d;
  logic          bus_err_q, bus_err_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    regs_q [16];
  logic [7:0]    regs_d [16];

  logic s_ad, s_cs, s_rd, s_wr;
  logic ad_fall, cs_rise, rd_rise, wr_rise;
  logic in_range, bus_we, wrap, tick;
  logic [7:0] rdata;
  logic [8:0] sec_inc, min_inc, hr_inc;

  assign {s_ad, s_cs, s_rd, s_wr} = sync_q;
  assign ad_fall  = prev_q[3] & ~s_ad;
  assign cs_rise  = ~prev_q[2] & s_cs;
  assign rd_rise  = ~prev_q[1] & s_rd;
  assign wr_rise  = ~prev_q[0] & s_wr;
  assign in_range = (addr_q[7:4] == 4'h0);
  assign rdata    = in_range ? regs_q[addr_q[3:0]] : 8'h00;

  // Returns {carry, next}; anything at or above lim wraps to zero with carry.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v >= lim) return {1'b1, 8'h00};
    if (v[3:0] >= 4'd9) return {1'b0, v[7:4] + 4'd1, 4'h0};
    return {1'b0, v + 8'd1};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q      <= 4'hF;
      sync_q      <= 4'hF;
      prev_q      <= 4'hF;
      data_meta_q <= 8'h00;
      data_sync_q <= 8'h00;
      data_prev_q <= 8'h00;
    end else begin
      meta_q      <= {AD, CS, RD, WR};
      sync_q      <= meta_q;
      prev_q      <= sync_q;
      data_meta_q <= ad_in;
      data_sync_q <= data_meta_q;
      data_prev_q <= data_sync_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= 8'h00;
      cnt_q       <= '0;
      ad_out_q    <= 8'h00;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      bus_err_q   <= 1'b0;
      presc_q     <= '0;
      for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
      regs_q[15]  <= 8'h01;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      ad_out_q    <= ad_out_d;
      wr_strobe_q <= wr_strobe_d;
      rd_strobe_q <= rd_strobe_d;
      bus_err_q   <= bus_err_d;
      presc_q     <= presc_d;
      regs_q      <= regs_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    ad_out_d    = ad_out_q;
    wr_strobe_d = 1'b0;
    rd_strobe_d = 1'b0;
    bus_err_d   = 1'b0;
    bus_we      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!s_ad && !s_cs && !s_wr) state_d = StAddr;
      end
      StAddr: begin
        if (wr_rise && !s_ad) begin
          addr_d  = data_prev_q;
          cnt_d   = '0;
          state_d = StWait;
        end else if (cs_rise) begin
          bus_err_d = 1'b1;
          state_d   = StIdle;
        end
      end
      StWait: begin
        if (ad_fall || (!s_rd && !s_wr) || cnt_q == TW'(TIMEOUT - 1)) begin
          bus_err_d = 1'b1;
          state_d   = StIdle;
        end else if (s_ad && !s_cs && !s_rd) begin
          ad_out_d    = rdata;
          rd_strobe_d = 1'b1;
          state_d     = StRead;
        end else if (s_ad && !s_cs && !s_wr) begin
          state_d = StWrite;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRead: begin
        if (ad_fall) begin
          bus_err_d = 1'b1;
          state_d   = StIdle;
        end else if (rd_rise || cs_rise) begin
          state_d = StIdle;
        end
      end
      StWrite: begin
        if (ad_fall) begin
          bus_err_d = 1'b1;
          state_d   = StIdle;
        end else if (wr_rise) begin
          bus_we      = in_range;
          wr_strobe_d = in_range;
          state_d     = StIdle;
        end else if (cs_rise) begin
          bus_err_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    regs_d  = regs_q;
    wrap    = (presc_q == PW'(TICK_DIV - 1));
    presc_d = wrap ? '0 : presc_q + 1'b1;
    sec_inc = bcd_inc(regs_q[0], 8'h59);
    min_inc = bcd_inc(regs_q[1], 8'h59);
    hr_inc  = bcd_inc(regs_q[2], 8'h23);
    // A bus write to a time register drops the whole tick for that cycle
    tick    = wrap && regs_q[15][0] && !(bus_we && addr_q[3:0] <= 4'd2);
    if (tick) begin
      regs_d[0] = sec_inc[7:0];
      if (sec_inc[8]) begin
        regs_d[1] = min_inc[7:0];
        if (min_inc[8]) regs_d[2] = hr_inc[7:0];
      end
    end
    if (bus_we) regs_d[addr_q[3:0]] = data_prev_q;
  end

  always_comb begin
    ad_oe     = (state_q == StRead);
    ad_out    = ad_out_q;
    wr_strobe = wr_strobe_q;
    rd_strobe = rd_strobe_q;
    bus_err   = bus_err_q;
    time_out  = {regs_q[2], regs_q[1], regs_q[0]};
  end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed bench for rtc_bus_responder: vector table of bus transactions plus
// hand-written sequences for timekeeping, aborts, timeout and reset mid-read.
module tb_rtc_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        AD, CS, RD, WR;
  logic [7:0]  ad_in;
  logic [7:0]  ad_out;
  logic        ad_oe, wr_strobe, rd_strobe, bus_err;
  logic [23:0] time_out;

  int passed = 0;
  int total  = 0;
  int n_ws = 0, n_rs = 0, n_err = 0;

  logic        watch_arm = 1'b0;
  logic        watch_hit = 1'b0;
  logic [23:0] watch_ref = '0;
  logic [23:0] watch_val = '0;

  rtc_bus_responder #(.TICK_DIV(4), .TIMEOUT(63)) dut (
    .clk       (clk),
    .reset     (reset),
    .AD        (AD),
    .CS        (CS),
    .RD        (RD),
    .WR        (WR),
    .ad_in     (ad_in),
    .ad_out    (ad_out),
    .ad_oe     (ad_oe),
    .wr_strobe (wr_strobe),
    .rd_strobe (rd_strobe),
    .bus_err   (bus_err),
    .time_out  (time_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe) n_ws++;
    if (rd_strobe) n_rs++;
    if (bus_err) n_err++;
    if (watch_arm && time_out != watch_ref) begin
      watch_val = time_out;
      watch_hit = 1'b1;
      watch_arm = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before 2ms");
    $fatal(1, "bench timeout");
  end

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
    int         exp_ws;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, want %0h", name, act, exp);
    else passed++;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [7:0] a);
    AD = 1'b0; CS = 1'b0; ad_in = a; WR = 1'b0;
    cyc(6);
    WR = 1'b1;
    cyc(4);
    CS = 1'b1;
    cyc(2);
    AD = 1'b1;
    cyc(2);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    addr_phase(a);
    CS = 1'b0; ad_in = d; WR = 1'b0;
    cyc(6);
    WR = 1'b1;
    cyc(4);
    CS = 1'b1;
    cyc(3);
  endtask

  task automatic bus_read(input logic [7:0] a, output logic oe, output logic [7:0] dat,
                          output logic oe_after);
    addr_phase(a);
    CS = 1'b0; RD = 1'b0;
    cyc(8);
    oe  = ad_oe;
    dat = ad_out;
    RD = 1'b1;
    cyc(3);
    oe_after = ad_oe;
    CS = 1'b1;
    cyc(3);
  endtask

  task automatic wait_change(input logic [23:0] ref_val, input logic [7:0] run_val);
    watch_ref = ref_val;
    watch_hit = 1'b0;
    watch_arm = 1'b1;
    bus_write(8'h0F, run_val);
    for (int k = 0; k < 20 && !watch_hit; k++) cyc(1);
  endtask

  vec_t vecs [11];
  logic oe, oe_after;
  logic [7:0] dat;
  int ws0, rs0, e0;

  initial begin
    vecs[0]  = '{wr: 1'b1, addr: 8'h0F, data: 8'h00, exp_rd: 8'h00, exp_ws: 1};
    vecs[1]  = '{wr: 1'b1, addr: 8'h05, data: 8'hA5, exp_rd: 8'h00, exp_ws: 1};
    vecs[2]  = '{wr: 1'b0, addr: 8'h05, data: 8'h00, exp_rd: 8'hA5, exp_ws: 0};
    vecs[3]  = '{wr: 1'b1, addr: 8'h20, data: 8'h11, exp_rd: 8'h00, exp_ws: 0};
    vecs[4]  = '{wr: 1'b0, addr: 8'h20, data: 8'h00, exp_rd: 8'h00, exp_ws: 0};
    vecs[5]  = '{wr: 1'b1, addr: 8'h0E, data: 8'h3C, exp_rd: 8'h00, exp_ws: 1};
    vecs[6]  = '{wr: 1'b0, addr: 8'h0E, data: 8'h00, exp_rd: 8'h3C, exp_ws: 0};
    vecs[7]  = '{wr: 1'b0, addr: 8'h0F, data: 8'h00, exp_rd: 8'h00, exp_ws: 0};
    vecs[8]  = '{wr: 1'b1, addr: 8'h03, data: 8'hFF, exp_rd: 8'h00, exp_ws: 1};
    vecs[9]  = '{wr: 1'b0, addr: 8'h03, data: 8'h00, exp_rd: 8'hFF, exp_ws: 0};
    vecs[10] = '{wr: 1'b0, addr: 8'h05, data: 8'h00, exp_rd: 8'hA5, exp_ws: 0};

    reset = 1'b1; AD = 1'b1; CS = 1'b1; RD = 1'b1; WR = 1'b1; ad_in = 8'h00;
    cyc(3);
    check("rst_ad_oe", ad_oe, 1'b0);
    check("rst_ad_out", ad_out, 8'h00);
    check("rst_time", time_out, 24'h000000);
    check("rst_strobes", {wr_strobe, rd_strobe, bus_err}, 3'b000);
    reset = 1'b0;
    cyc(2);

    for (int i = 0; i < 11; i++) begin
      ws0 = n_ws; rs0 = n_rs; e0 = n_err;
      if (vecs[i].wr) begin
        bus_write(vecs[i].addr, vecs[i].data);
        check($sformatf("vec%0d_wr_strobe", i), n_ws - ws0, vecs[i].exp_ws);
      end else begin
        bus_read(vecs[i].addr, oe, dat, oe_after);
        check($sformatf("vec%0d_oe", i), oe, 1'b1);
        check($sformatf("vec%0d_data", i), dat, vecs[i].exp_rd);
        check($sformatf("vec%0d_oe_release", i), oe_after, 1'b0);
        check($sformatf("vec%0d_rd_strobe", i), n_rs - rs0, 1);
      end
      check($sformatf("vec%0d_bus_err", i), n_err - e0, 0);
    end

    // Full rollover 23:59:59 -> 00:00:00
    bus_write(8'h00, 8'h59);
    bus_write(8'h01, 8'h59);
    bus_write(8'h02, 8'h23);
    check("roll_preload", time_out, 24'h235959);
    wait_change(24'h235959, 8'h01);
    check("roll_tick_seen", watch_hit, 1'b1);
    check("roll_value", watch_val, 24'h000000);
    bus_write(8'h0F, 8'h00);

    // Out-of-range seconds normalise on the next tick and carry into minutes
    bus_write(8'h02, 8'h05);
    bus_write(8'h01, 8'h10);
    bus_write(8'h00, 8'h7A);
    check("oor_preload", time_out, 24'h05107A);
    wait_change(24'h05107A, 8'h01);
    check("oor_tick_seen", watch_hit, 1'b1);
    check("oor_value", watch_val, 24'h051100);
    bus_write(8'h0F, 8'h00);

    // CS rises during the address phase
    ws0 = n_ws; e0 = n_err;
    AD = 1'b0; CS = 1'b0; ad_in = 8'h05; WR = 1'b0;
    cyc(6);
    CS = 1'b1;
    cyc(6);
    WR = 1'b1; AD = 1'b1;
    cyc(4);
    check("cs_abort_err", n_err - e0, 1);
    check("cs_abort_no_ws", n_ws - ws0, 0);

    // RD and WR both low in the data phase
    ws0 = n_ws; rs0 = n_rs; e0 = n_err;
    addr_phase(8'h03);
    CS = 1'b0; RD = 1'b0; WR = 1'b0; ad_in = 8'h00;
    cyc(6);
    RD = 1'b1; WR = 1'b1; CS = 1'b1;
    cyc(4);
    check("rdwr_err", n_err - e0, 1);
    check("rdwr_no_strobe", (n_ws - ws0) + (n_rs - rs0), 0);

    // WAIT_DATA timeout
    e0 = n_err;
    addr_phase(8'h05);
    cyc(70);
    check("timeout_err", n_err - e0, 1);
    bus_read(8'h05, oe, dat, oe_after);
    check("timeout_reg5", dat, 8'hA5);
    bus_read(8'h03, oe, dat, oe_after);
    check("rdwr_reg3", dat, 8'hFF);

    // Reset asserted mid-read
    addr_phase(8'h05);
    CS = 1'b0; RD = 1'b0;
    cyc(8);
    check("pre_reset_oe", ad_oe, 1'b1);
    reset = 1'b1;
    #1;
    check("reset_oe", ad_oe, 1'b0);
    check("reset_time", time_out, 24'h000000);
    RD = 1'b1; CS = 1'b1; AD = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(3);
    bus_read(8'h0F, oe, dat, oe_after);
    check("post_reset_reg15", dat, 8'h01);
    bus_read(8'h05, oe, dat, oe_after);
    check("post_reset_reg5", dat, 8'h00);
    bus_read(8'h0E, oe, dat, oe_after);
    check("post_reset_reg14", dat, 8'h00);
    bus_read(8'h03, oe, dat, oe_after);
    check("post_reset_reg3", dat, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
